dmg_timer: RTL

Timer/divider unit: 16-bit free-running system counter (DIV), 8-bit counter TIMA with modulo reload from TMA, control register TAC, and timer interrupt request. It sits between the CPU register bus (0xFF04–0xFF07) and the interrupt controller. It drives the reload (load/data) side of counter cells: it decides when TIMA is loaded and with what, instead of merely toggling.

---
 rtl/dmg_timer_pkg.sv | 36 +++
 rtl/dmg_timer_tick.sv | 55 +++++
 rtl/dmg_timer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmg_timer_pkg.sv
// dmg_timer_pkg: shared constants, FSM state type and TAC select decode for
// the DMG timer/divider. Optional feature macro: DMG_TIMER_GLITCH_EN.
package dmg_timer_pkg;

    // CPU register map offsets (0xFF04..0xFF07)
    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_TIMA = 2'd1;
    localparam logic [1:0] ADDR_TMA  = 2'd2;
    localparam logic [1:0] ADDR_TAC  = 2'd3;

    // Length of the overflow delay and of the reload window, in T-cycles
    localparam int OVF_CYCLES    = 4;
    localparam int RELOAD_CYCLES = 4;

    localparam logic [1:0] OVF_LAST    = 2'(OVF_CYCLES - 1);
    localparam logic [1:0] RELOAD_LAST = 2'(RELOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    // TAC[1:0] picks which system-counter bit clocks TIMA
    function automatic logic [3:0] tac_div_bit(input logic [1:0] sel);
        logic [3:0] bit_idx;
        case (sel)
            2'b00:   bit_idx = 4'd9;
            2'b01:   bit_idx = 4'd3;
            2'b10:   bit_idx = 4'd5;
            default: bit_idx = 4'd7;
        endcase
        return bit_idx;
    endfunction

endpackage

// File: rtl/dmg_timer_tick.sv
// dmg_timer_tick: selects the divider bit, gates it with the TAC enable and
// turns its falling edge into a one-cycle TIMA tick.
// DMG_TIMER_GLITCH_EN defined: DIV/TAC writes that drop the gate also tick.
// Undefined: only edges caused by normal counting tick.
module dmg_timer_tick
    import dmg_timer_pkg::*;
(
    input  logic        nclk,
    input  logic        reset,
    input  logic [15:0] div,
    input  logic [2:0]  tac,
    input  logic        div_wr,
    input  logic        tac_wr,
    output logic        tick
);

    logic w_sel;
    logic w_gate;
    logic r_gate_prev;

    assign w_sel  = div[tac_div_bit(tac[1:0])];
    assign w_gate = w_sel & tac[2];

    // Remember the gate level seen in the previous cycle
    always_ff @(negedge nclk) begin
        if (reset) begin
            r_gate_prev <= 1'b0;
        end else begin
            r_gate_prev <= w_gate;
        end
    end

`ifdef DMG_TIMER_GLITCH_EN
    logic w_unused_wr;
    assign w_unused_wr = div_wr | tac_wr;
    assign tick = r_gate_prev & ~w_gate;
`else
    // A write cycle marks the next cycle as having no valid history: that is
    // the same as reloading the previous-gate register with the new gate,
    // so a gate drop caused by the write itself never looks like an edge.
    logic r_wr_last;

    // Flag cycles that follow a DIV or TAC write
    always_ff @(negedge nclk) begin
        if (reset) begin
            r_wr_last <= 1'b0;
        end else begin
            r_wr_last <= div_wr | tac_wr;
        end
    end

    assign tick = ~r_wr_last & r_gate_prev & ~w_gate;
`endif

endmodule

// File: rtl/dmg_timer.sv
// dmg_timer: DIV system counter, TIMA/TMA/TAC registers, delayed overflow
// reload state machine and CPU read mux. All state changes on the falling
// edge of nclk. Optional feature macro: DMG_TIMER_GLITCH_EN (see tick unit).
module dmg_timer
    import dmg_timer_pkg::*;
(
    input  logic        nclk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        wr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [15:0] div,
    output logic        irq
);

    logic [15:0] r_div;
    logic [7:0]  r_tima;
    logic [7:0]  r_tma;
    logic [2:0]  r_tac;
    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_irq;

    logic w_div_wr;
    logic w_tima_wr;
    logic w_tma_wr;
    logic w_tac_wr;
    logic w_tick;

    assign w_div_wr  = wr && (addr == ADDR_DIV);
    assign w_tima_wr = wr && (addr == ADDR_TIMA);
    assign w_tma_wr  = wr && (addr == ADDR_TMA);
    assign w_tac_wr  = wr && (addr == ADDR_TAC);

    dmg_timer_tick u_tick (
        .nclk   (nclk),
        .reset  (reset),
        .div    (r_div),
        .tac    (r_tac),
        .div_wr (w_div_wr),
        .tac_wr (w_tac_wr),
        .tick   (w_tick)
    );

    // Free-running system counter; any DIV write clears it instead of counting
    always_ff @(negedge nclk) begin
        if (reset) begin
            r_div <= 16'h0000;
        end else if (w_div_wr) begin
            r_div <= 16'h0000;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // TIMA/TMA/TAC registers and the overflow -> reload sequencer
    always_ff @(negedge nclk) begin
        if (reset) begin
            r_tima  <= 8'h00;
            r_tma   <= 8'h00;
            r_tac   <= 3'b000;
            r_state <= RUN;
            r_cnt   <= 2'd0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_tma_wr) begin
                r_tma <= wdata;
            end
            if (w_tac_wr) begin
                r_tac <= wdata[2:0];
            end
            case (r_state)
                RUN: begin
                    // A CPU write beats a coincident tick
                    if (w_tima_wr) begin
                        r_tima <= wdata;
                    end else if (w_tick) begin
                        if (r_tima == 8'hFF) begin
                            r_tima  <= 8'h00;
                            r_state <= OVF;
                            r_cnt   <= 2'd0;
                        end else begin
                            r_tima <= r_tima + 8'd1;
                        end
                    end
                end
                OVF: begin
                    if (w_tima_wr) begin
                        // CPU wrote TIMA before the reload: abort, no interrupt
                        r_tima  <= wdata;
                        r_state <= RUN;
                    end else if (r_cnt == OVF_LAST) begin
                        r_tima  <= r_tma;
                        r_irq   <= 1'b1;
                        r_state <= RELOAD;
                        r_cnt   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                        if (w_tick) begin
                            r_tima <= r_tima + 8'd1;
                        end
                    end
                end
                RELOAD: begin
                    // TIMA writes are dropped; TMA writes pass through to TIMA
                    if (w_tma_wr) begin
                        r_tima <= wdata;
                    end else if (w_tick) begin
                        r_tima <= r_tima + 8'd1;
                    end
                    if (r_cnt == RELOAD_LAST) begin
                        r_state <= RUN;
                        r_cnt   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 2'd0;
                end
            endcase
        end
    end

    // CPU read mux straight from registered state
    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_DIV:  rdata = r_div[15:8];
            ADDR_TIMA: rdata = r_tima;
            ADDR_TMA:  rdata = r_tma;
            default:   rdata = {5'b11111, r_tac};
        endcase
    end

    assign div = r_div;
    assign irq = r_irq;

endmodule
